// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-fetch and VGA pin bundle between renderer, generator and connector
interface vga_timing_gen_if #(
  parameter int CH_W  = 4,
  parameter int CNT_W = 11
);
  logic [3*CH_W-1:0] vga_data;
  logic [CNT_W-1:0]  h_addr;
  logic [CNT_W-1:0]  v_addr;
  logic              addr_valid;
  logic              line_start;
  logic              frame_start;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [CH_W-1:0]   vga_r;
  logic [CH_W-1:0]   vga_g;
  logic [CH_W-1:0]   vga_b;

  modport master (
    input  vga_data,
    output h_addr, v_addr, addr_valid, line_start, frame_start,
    output hsync, vsync, de, vga_r, vga_g, vga_b
  );

  modport slave (
    output vga_data,
    input  h_addr, v_addr, addr_valid, line_start, frame_start,
    input  hsync, vsync, de, vga_r, vga_g, vga_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator with pixel-fetch latency alignment
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CH_W     = 4,
  parameter int CNT_W    = 11,
  parameter int DATA_LAT = 1
) (
  input  logic              pclk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL - 1) >= (1 << CNT_W) || (V_TOTAL - 1) >= (1 << CNT_W)) begin : g_cnt_w_err
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (DATA_LAT < 0 || DATA_LAT > 7) begin : g_lat_err
    $error("vga_timing_gen: DATA_LAT must be 0..7");
  end

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_SY_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SY_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SY_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SY_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic h_act, v_act, hs_raw, vs_raw, av_raw;

  always_comb begin
    h_act  = (h_cnt_q <= H_ACT_LAST);
    v_act  = (v_cnt_q <= V_ACT_LAST);
    hs_raw = (h_cnt_q >= H_SY_BEG) && (h_cnt_q <= H_SY_LAST);
    vs_raw = (v_cnt_q >= V_SY_BEG) && (v_cnt_q <= V_SY_LAST);
    av_raw = h_act && v_act;
  end

  // Fetch-side outputs are gated by reset so the renderer sees nothing while held.
  assign vga.h_addr      = (reset && h_act) ? h_cnt_q : '0;
  assign vga.v_addr      = (reset && v_act) ? v_cnt_q : '0;
  assign vga.addr_valid  = reset && av_raw;
  assign vga.line_start  = reset && (h_cnt_q == '0);
  assign vga.frame_start = reset && (h_cnt_q == '0) && (v_cnt_q == '0);

  // tap = {hs, vs, av} aligned with the colour returned for that pixel.
  logic [2:0] tap;

  if (DATA_LAT == 0) begin : g_no_pipe
    assign tap = {hs_raw, vs_raw, av_raw};
  end else begin : g_pipe
    logic [2:0] pipe_q [DATA_LAT];

    always_ff @(posedge pclk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DATA_LAT; i++) pipe_q[i] <= 3'b000;
      end else begin
        pipe_q[0] <= {hs_raw, vs_raw, av_raw};
        for (int i = 1; i < DATA_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign tap = pipe_q[DATA_LAT-1];
  end

  logic              hsync_q, vsync_q, de_q;
  logic [3*CH_W-1:0] rgb_q;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= tap[2] ? HS_POL : ~HS_POL;
      vsync_q <= tap[1] ? VS_POL : ~VS_POL;
      de_q    <= tap[0];
      rgb_q   <= tap[0] ? vga.vga_data : '0;
    end
  end

  assign vga.hsync = hsync_q;
  assign vga.vsync = vsync_q;
  assign vga.de    = de_q;
  assign vga.vga_r = rgb_q[3*CH_W-1 -: CH_W];
  assign vga.vga_g = rgb_q[2*CH_W-1 -: CH_W];
  assign vga.vga_b = rgb_q[CH_W-1:0];

endmodule
